// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding,
// error read value, default geometry and the address legality check.
package mem_pkg;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_STATES = 2;

    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Word-aligned and inside the RAM; works for non power-of-two depths.
    function automatic logic addr_legal(
        input logic [31:0] a,
        input int unsigned depth
    );
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < depth);
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Single-port word RAM: one-edge write, one-edge registered read.
// The read register can be forced to the error value on an illegal access.
module mem_word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int ADDR_BITS   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic                 i_clr,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= ERR_DATA;
        end else if (i_clr) begin
            r_rdata <= ERR_DATA;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES extra
// cycles, single-cycle mem_ready strobe with mem_error on illegal access.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_error
);

    localparam int ADDR_BITS =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic [ADDR_BITS-1:0] r_idx;
    logic [31:0]          r_wdata;
    logic                 r_write;
    logic                 r_legal;

    logic r_ready;
    logic r_busy;
    logic r_error;
    logic w_ready_nxt;
    logic w_busy_nxt;
    logic w_error_nxt;

    logic w_accept;
    logic w_access;
    logic w_we;
    logic w_re;
    logic w_clr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_error_nxt = 1'b0;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (mem_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = WS;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                w_cnt_nxt = 4'(r_cnt - 4'd1);
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_access    = 1'b1;
                w_ready_nxt = 1'b1;
                w_error_nxt = ~r_legal;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Request fields are captured once; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_idx   <= address[ADDR_BITS+1:2];
            r_wdata <= write_data;
            r_write <= mem_write;
            r_legal <= addr_legal(address, DEPTH_WORDS);
        end
    end

    // A reset landing on the ACCESS edge still blocks the write.
    assign w_we  = w_access & r_legal & r_write & reset;
    assign w_re  = w_access & r_legal & ~r_write;
    assign w_clr = w_access & ~r_legal;

    mem_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_clr  (w_clr),
        .i_addr (r_idx),
        .i_wdata(r_wdata),
        .o_rdata(read_data)
    );

    assign mem_ready = r_ready;
    assign mem_busy  = r_busy;
    assign mem_error = r_error;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (0 and 2 wait states),
// scoreboard of expected completions checked on each mem_ready.
module tb_mem_responder;

    typedef struct {
        int          s;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req  [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        err  [2];

    logic [31:0] mm  [2][256];
    logic [31:0] mrd [2];
    exp_t        q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clock     (clk),
        .reset     (rst),
        .mem_req   (req[0]),
        .mem_write (wr[0]),
        .address   (addr[0]),
        .write_data(wd[0]),
        .read_data (rd[0]),
        .mem_ready (rdy[0]),
        .mem_busy  (busy[0]),
        .mem_error (err[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut2 (
        .clock     (clk),
        .reset     (rst),
        .mem_req   (req[1]),
        .mem_write (wr[1]),
        .address   (addr[1]),
        .write_data(wd[1]),
        .read_data (rd[1]),
        .mem_ready (rdy[1]),
        .mem_busy  (busy[1]),
        .mem_error (err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: compute the completion this request should produce.
    task automatic push(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
        exp_t e;
        logic ok;
        ok = (a[1:0] == 2'b00) && (a < 32'h400);
        if (!ok) begin
            mrd[s] = 32'h0;
        end else if (w) begin
            mm[s][a[9:2]] = d;
        end else begin
            mrd[s] = mm[s][a[9:2]];
        end
        e.s    = s;
        e.data = mrd[s];
        e.err  = ~ok;
        q.push_back(e);
    endtask

    task automatic pop_chk(input int s, input string tag);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_dut"}, s, e.s);
            check({tag, "_data"}, rd[s], e.data);
            check({tag, "_err"}, 32'(err[s]), 32'(e.err));
        end
    endtask

    task automatic issue(input int s, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        req[s]  = 1'b1;
        wr[s]   = w;
        addr[s] = a;
        wd[s]   = d;
        push(s, w, a, d);
    endtask

    // Waits for the accepting edge, then for mem_ready within a bound.
    task automatic complete(input int s, input int ws, input string tag);
        int  n;
        bit  got;
        @(posedge clk);
        got = 0;
        n   = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            n = i;
            if (i == 1) begin
                check({tag, "_busy_on"}, 32'(busy[s]), 32'd1);
                req[s]  = 1'b0;
                addr[s] = 32'hDEAD_BEE0;
                wd[s]   = 32'h0BAD_0BAD;
            end
            if (rdy[s]) got = 1;
        end
        if (!got) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=no_ready expected=ready", tag);
        end
        check({tag, "_lat"}, n, ws + 2);
        pop_chk(s, tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(rdy[s]), 32'd0);
        check({tag, "_busy_off"}, 32'(busy[s]), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s]  = 1'b0;
            wr[s]   = 1'b0;
            addr[s] = 32'h0;
            wd[s]   = 32'h0;
            mrd[s]  = 32'h0;
        end
        rst = 1'b0;

        // Reset with a request pending; it must not be taken until release.
        req[1]  = 1'b1;
        wr[1]   = 1'b1;
        addr[1] = 32'h40;
        wd[1]   = 32'hCAFE_F00D;
        push(1, 1'b1, 32'h40, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(rdy[1]), 32'd0);
            check("rst_busy", 32'(busy[1]), 32'd0);
            check("rst_err", 32'(err[1]), 32'd0);
            check("rst_rdata", rd[1], 32'h0);
        end
        rst = 1'b1;
        complete(1, 2, "wr40");

        issue(1, 1'b0, 32'h40, 32'h0);
        complete(1, 2, "rd40");

        issue(1, 1'b1, 32'h8, 32'h1111_2222);
        complete(1, 2, "wr08");

        issue(0, 1'b1, 32'h0, 32'hA5A5_0000);
        complete(0, 0, "pre0");
        issue(0, 1'b1, 32'h4, 32'h5A5A_1111);
        complete(0, 0, "pre4");

        // Zero wait states, request held high across two reads.
        @(negedge clk);
        req[0]  = 1'b1;
        wr[0]   = 1'b0;
        addr[0] = 32'h0;
        push(0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        addr[0] = 32'h4;
        push(0, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        check("b2b_rdy1", 32'(rdy[0]), 32'd1);
        pop_chk(0, "b2b_rd0");
        @(negedge clk);
        check("b2b_gap", 32'(rdy[0]), 32'd0);
        check("b2b_busy", 32'(busy[0]), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        check("b2b_rdy2", 32'(rdy[0]), 32'd1);
        pop_chk(0, "b2b_rd4");
        @(negedge clk);
        check("b2b_end", 32'(rdy[0]), 32'd0);
        check("b2b_idle", 32'(busy[0]), 32'd0);

        issue(1, 1'b1, 32'h42, 32'h0000_1234);
        complete(1, 2, "mis42");
        issue(1, 1'b0, 32'h40, 32'h0);
        complete(1, 2, "rd40b");
        issue(1, 1'b0, 32'h400, 32'h0);
        complete(1, 2, "oor400");

        // Reset during WAIT of a write: the write must be dropped.
        @(negedge clk);
        req[1]  = 1'b1;
        wr[1]   = 1'b1;
        addr[1] = 32'h8;
        wd[1]   = 32'hFFFF_FFFF;
        @(negedge clk);
        check("abort_busy", 32'(busy[1]), 32'd1);
        req[1] = 1'b0;
        rst    = 1'b0;
        mrd[0] = 32'h0;
        mrd[1] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_rdy", 32'(rdy[1]), 32'd0);
            check("abort_busy0", 32'(busy[1]), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_quiet", 32'(rdy[1]), 32'd0);
        end
        issue(1, 1'b0, 32'h8, 32'h0);
        complete(1, 2, "rd08");

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle datapath's shared instruction/data memory port.
- Accepts one read or write request at a time and models a configurable number of wait states.
- Returns read data with a single-cycle completion strobe.
- Sits between the datapath's address/data_out/data_in pins and a word-organised RAM; the control FSM stalls on mem_ready.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; word index = address[ADDR_BITS+1:2], ADDR_BITS = clog2(DEPTH_WORDS).
- WAIT_STATES, 2, extra cycles inserted before completion; legal range 0..15.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clock edge.
- mem_req  in  1  request valid; sampled only in IDLE.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- address  in  32  byte address from the datapath.
- write_data  in  32  store data (the datapath's data_out).
- read_data  out  32  load data (the datapath's data_in).
- mem_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high from acceptance through the mem_ready cycle inclusive.
- mem_error  out  1  pulses with mem_ready when the access was illegal.

Behaviour:
- Clock and reset: one clock, named clock. Reset, named reset, is synchronous and active-low.
- Reset values: while reset=0 at an edge, state<=IDLE, counter<=0, read_data<=0, and mem_ready, mem_busy, mem_error <=0. RAM contents are not cleared.
- Reset during WAIT or ACCESS aborts the transaction. A pending write is never performed.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - If mem_req=1 at edge k, latch address, mem_write, write_data and legality.
  - counter<=WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
  - mem_busy<=1.
- WAIT: counter decrements each edge. When counter reaches 1, the next state is ACCESS.
- ACCESS, one edge:
  - Legal write: RAM[idx]<=latched data.
  - Legal read: read_data<=RAM[idx].
  - mem_ready<=1 for exactly one cycle. Next state is IDLE.
- Latency: request accepted at edge k; mem_ready is high in the cycle after edge k+1+WAIT_STATES.
  - mem_busy drops in the following cycle.
  - Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Illegal access: address[1:0]!=0 or word index >= DEPTH_WORDS.
  - No RAM write.
  - read_data<=32'h0000_0000.
  - mem_error<=1 together with mem_ready.
- read_data holds its value until the next completed read, illegal access or reset. Writes do not alter read_data.
- mem_req while busy is ignored; there is no queue.
  - If mem_req is still high in IDLE, it is re-accepted. A held request therefore re-issues.
  - The control FSM must deassert mem_req in the mem_ready cycle.
- Inputs are not re-sampled after acceptance. Changes to address or write_data during WAIT have no effect.
- Read-after-write to the same word in consecutive transactions returns the new data.

Decomposition:
- Shared package mem_pkg:
  - state encoding IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2.
  - ERR_DATA=32'h0.
  - default DEPTH_WORDS and WAIT_STATES.
- One sub-module, mem_word_ram: single-port synchronous RAM with a one-edge write and a one-edge registered read, parameterised by DEPTH_WORDS. The FSM and the legality check stay in mem_responder.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles with mem_req=1, then reset=1 → mem_ready, mem_busy, mem_error and read_data stay 0 during reset. The first acceptance occurs on the edge after reset releases.
- Write then read, WAIT_STATES=2:
  - Write 0xCAFEF00D to 0x40 → mem_ready pulses in the cycle after edge k+3 for exactly 1 cycle, and mem_error=0.
  - Read 0x40 → read_data=0xCAFEF00D in the mem_ready cycle.
- WAIT_STATES=0, back-to-back reads of 0x0 and 0x4 with mem_req held high → mem_ready pulses every 2nd cycle, and read_data matches preloaded words.
- Misaligned write to 0x42 with data 0x1234 → mem_ready and mem_error pulse together, read_data=0. A subsequent read of 0x40 returns the old value.
- Out-of-range read at 0x400 (DEPTH_WORDS=256) → mem_error=1, read_data=0.
- Reset asserted in WAIT of a write of 0xFFFFFFFF to 0x8 → no mem_ready, and a later read of 0x8 returns the prior contents.
